// File: rtl/vpu_coeff_pkg.sv
// Shared types and constants for the rotation-coefficient ROM arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vpu_coeff_pkg;

  localparam int ANGLE_W = 4;
  localparam int COEF_W  = 16;
  // Requester ID field is sized for the largest supported NREQ (8).
  localparam int ID_W    = 3;

  // Angle index: bit 3 = negative, bits 2:0 select the magnitude.
  localparam logic [ANGLE_W-1:0] ANG_P3   = 4'h0;
  localparam logic [ANGLE_W-1:0] ANG_P15  = 4'h1;
  localparam logic [ANGLE_W-1:0] ANG_P30  = 4'h2;
  localparam logic [ANGLE_W-1:0] ANG_P45  = 4'h3;
  localparam logic [ANGLE_W-1:0] ANG_P60  = 4'h4;
  localparam logic [ANGLE_W-1:0] ANG_P75  = 4'h5;
  localparam logic [ANGLE_W-1:0] ANG_P90  = 4'h6;
  localparam logic [ANGLE_W-1:0] ANG_P180 = 4'h7;
  localparam logic [ANGLE_W-1:0] ANG_M3   = 4'h8;
  localparam logic [ANGLE_W-1:0] ANG_M15  = 4'h9;
  localparam logic [ANGLE_W-1:0] ANG_M30  = 4'hA;
  localparam logic [ANGLE_W-1:0] ANG_M45  = 4'hB;
  localparam logic [ANGLE_W-1:0] ANG_M60  = 4'hC;
  localparam logic [ANGLE_W-1:0] ANG_M75  = 4'hD;
  localparam logic [ANGLE_W-1:0] ANG_M90  = 4'hE;
  localparam logic [ANGLE_W-1:0] ANG_M180 = 4'hF;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [ANGLE_W-1:0] angle;
    logic [COEF_W-1:0]  c1;
    logic [COEF_W-1:0]  c2;
    logic [COEF_W-1:0]  c3;
    logic [COEF_W-1:0]  c4;
  } coeff_rsp_t;

endpackage

// File: rtl/coeff_rsp_fifo.sv
// First-word-fall-through response FIFO of coeff_rsp_t, exposes its occupancy.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: none internally; the producer must never push when full.
module coeff_rsp_fifo
  import vpu_coeff_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  coeff_rsp_t    push_dat,
  input  logic          pop,
  output coeff_rsp_t    head,
  output logic [CW-1:0] occ
);

  coeff_rsp_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop && (occ != '0);
  assign head   = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage is cleared on reset so the head reads as zero when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy tracking; push+pop together leaves occ unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // The upstream credit scheme must make a push into a full FIFO impossible.
  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !do_pop && (occ == CW'(DEPTH))));

endmodule

// File: rtl/coeff_rom_arbiter.sv
// Round-robin arbiter sharing the coefficient ROM; tags and buffers responses.
// Latency: grant at t, ROM data at t+1, response visible at t+2 (empty FIFO).
// Backpressure: credit check stops grants so at most DEPTH lookups are outstanding.
module coeff_rom_arbiter
  import vpu_coeff_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 2,
  localparam int IW = $clog2(NREQ),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [4*NREQ-1:0]    req_angle,
  output logic [NREQ-1:0]      req_ready,
  output logic [ANGLE_W-1:0]   rom_addr,
  input  logic [COEF_W-1:0]    rom_c1,
  input  logic [COEF_W-1:0]    rom_c2,
  input  logic [COEF_W-1:0]    rom_c3,
  input  logic [COEF_W-1:0]    rom_c4,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [ANGLE_W-1:0]   rsp_angle,
  output logic [COEF_W-1:0]    rsp_c1,
  output logic [COEF_W-1:0]    rsp_c2,
  output logic [COEF_W-1:0]    rsp_c3,
  output logic [COEF_W-1:0]    rsp_c4
);

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      gnt_id;
  logic               gnt_any;
  logic               grant;
  logic               issue;
  logic               inflight;
  logic               pop;
  logic [CW-1:0]      occ;
  logic [CW:0]        credit_use;
  logic [ANGLE_W-1:0] gnt_angle;
  logic [ANGLE_W-1:0] addr_q;
  logic [IW-1:0]      tag_id;
  logic [ANGLE_W-1:0] tag_angle;
  coeff_rsp_t         push_dat;
  coeff_rsp_t         head;

  assign rsp_valid = (occ != '0);
  assign pop       = rsp_valid & rsp_ready;

  // Credits: entries held + the lookup whose data lands this cycle - entry leaving.
  assign credit_use = {1'b0, occ} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue      = credit_use < (CW+1)'(DEPTH);

  // Round-robin search starting at rr_ptr, wrapping at NREQ.
  always_comb begin
    logic [IW:0] sum;
    logic [IW-1:0] idx;
    gnt_any = 1'b0;
    gnt_id  = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      idx = sum[IW-1:0];
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  assign grant     = issue && gnt_any && rst_n;
  assign gnt_angle = req_angle[{gnt_id, 2'b00} +: 4];
  // Address follows the granted angle, otherwise holds to avoid ROM toggling.
  assign rom_addr  = grant ? gnt_angle : addr_q;

  // One-hot grant, only when credits allow.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_id] = 1'b1;
  end

  // Round-robin pointer, address hold register and 1-stage tag pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      inflight  <= 1'b0;
      addr_q    <= '0;
      tag_id    <= '0;
      tag_angle <= '0;
    end else begin
      inflight <= grant;
      addr_q   <= rom_addr;
      if (grant) begin
        rr_ptr    <= (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);
        tag_id    <= gnt_id;
        tag_angle <= gnt_angle;
      end
    end
  end

  // Join the tag with the ROM data arriving one cycle after the grant.
  always_comb begin
    push_dat       = '0;
    push_dat.id    = ID_W'(tag_id);
    push_dat.angle = tag_angle;
    push_dat.c1    = rom_c1;
    push_dat.c2    = rom_c2;
    push_dat.c3    = rom_c3;
    push_dat.c4    = rom_c4;
  end

  coeff_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .occ      (occ)
  );

  assign rsp_id    = head.id[IW-1:0];
  assign rsp_angle = head.angle;
  assign rsp_c1    = head.c1;
  assign rsp_c2    = head.c2;
  assign rsp_c3    = head.c3;
  assign rsp_c4    = head.c4;

  // Upper ID bits are always zero for fewer than 8 requesters.
  if (IW < ID_W) begin : g_id_pad
    logic unused_id_bits;
    assign unused_id_bits = ^head.id[ID_W-1:IW];
  end

endmodule

// File: tb/tb_coeff_rom_arbiter.sv
module tb_coeff_rom_arbiter;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_angle;
  logic [3:0]  req_ready;
  logic [3:0]  rom_addr;
  logic [15:0] rom_c1 = '0, rom_c2 = '0, rom_c3 = '0, rom_c4 = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_angle;
  logic [15:0] rsp_c1, rsp_c2, rsp_c3, rsp_c4;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] ang;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Fixed per-requester angles: req0=+15, req1=-15, req2=+90, req3=-180.
  assign req_angle = {4'hF, 4'h6, 4'h9, 4'h1};

  function automatic logic [3:0] ang_of(input int id);
    case (id)
      0:       return 4'h1;
      1:       return 4'h9;
      2:       return 4'h6;
      default: return 4'hF;
    endcase
  endfunction

  // ROM model: registered read, one cycle latency.
  always @(posedge clk) begin
    rom_c1 <= 16'h1000 + 16'(rom_addr);
    rom_c2 <= 16'h2000 + 16'(rom_addr);
    rom_c3 <= 16'h3000 + 16'(rom_addr);
    rom_c4 <= 16'h4000 + 16'(rom_addr);
  end

  coeff_rom_arbiter #(.NREQ(NREQ), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_c1    (rom_c1),
    .rom_c2    (rom_c2),
    .rom_c3    (rom_c3),
    .rom_c4    (rom_c4),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_angle (rsp_angle),
    .rsp_c1    (rsp_c1),
    .rsp_c2    (rsp_c2),
    .rsp_c3    (rsp_c3),
    .rsp_c4    (rsp_c4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the expected one-hot grant and queue the response it must produce.
  task automatic grant(input string name, input int id);
    logic [3:0] one;
    one = 4'b0001 << id;
    chk(name, 32'(req_ready), 32'(one));
    exp_q.push_back('{id: 2'(id), ang: ang_of(id)});
  endtask

  // Monitor: every accepted response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d angle %0h, expected no response", rsp_id, rsp_angle);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id",    32'(rsp_id),    32'(e.id));
        chk("rsp_angle", 32'(rsp_angle), 32'(e.ang));
        chk("rsp_c1",    32'(rsp_c1),    32'(16'h1000 + 16'(e.ang)));
        chk("rsp_c2",    32'(rsp_c2),    32'(16'h2000 + 16'(e.ang)));
        chk("rsp_c3",    32'(rsp_c3),    32'(16'h3000 + 16'(e.ang)));
        chk("rsp_c4",    32'(rsp_c4),    32'(16'h4000 + 16'(e.ang)));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rom_addr",  32'(rom_addr),  0);
    chk("rst_rsp_c1",    32'(rsp_c1),    0);
    req_valid = '0;
    rst_n     = 1'b1;
    tick();

    // Single request from requester 2, angle 6: response two cycles later.
    req_valid = 4'b0100;
    #1;
    grant("single_gnt", 2);
    chk("single_rom_addr", 32'(rom_addr), 32'h6);
    tick();
    req_valid = '0;
    #1;
    chk("single_t1_rsp_valid", 32'(rsp_valid), 0);
    tick();
    #1;
    chk("single_t2_rsp_valid", 32'(rsp_valid), 1);
    tick();

    // Requester 3 alone brings the round-robin pointer back to 0.
    req_valid = 4'b1000;
    #1;
    grant("wrap_gnt", 3);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // All requesters valid, full throughput: 0,1,2,3,0,1,2,3.
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      grant("stream_gnt", k % 4);
      if (k >= 2) chk("stream_rsp_valid", 32'(rsp_valid), 1);
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // Backpressure: only DEPTH grants, then one per released pop.
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    #1; grant("bp_gnt0", 0); tick();
    #1; grant("bp_gnt1", 1); tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_blocked", 32'(req_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1; grant("bp_release_gnt", 2); tick();
    rsp_ready = 1'b0;
    #1; chk("bp_reblocked", 32'(req_ready), 0); tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) tick();

    // Push and pop together at occ=1, inflight=1 (pointer now at 3).
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    #1; grant("pp_gnt_a", 3); tick();
    req_valid = 4'b0001;
    #1; grant("pp_gnt_b", 0); tick();
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    chk("pp_rsp_valid", 32'(rsp_valid), 1);
    grant("pp_gnt_c", 1);
    tick();
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1;
    chk("pp_occ_held", 32'(req_ready), 0);
    chk("pp_head_id", 32'(rsp_id), 0);
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) tick();

    // Sparse requesters {1,3} with pointer at 2: 3, 1, 3.
    req_valid = 4'b1010;
    #1; grant("sparse_gnt0", 3); tick();
    #1; grant("sparse_gnt1", 1); tick();
    #1; grant("sparse_gnt2", 3); tick();
    req_valid = '0;
    repeat (4) tick();

    // Reset with one entry buffered and one lookup in flight.
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    #1; grant("prerst_gnt_a", 2); tick();
    req_valid = 4'b1000;
    #1; grant("prerst_gnt_b", 3); tick();
    req_valid = 4'hF;
    #1;
    chk("prerst_rsp_valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_async_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_async_rsp_id",    32'(rsp_id),    0);
    chk("rst_async_rsp_angle", 32'(rsp_angle), 0);
    chk("rst_async_req_ready", 32'(req_ready), 0);
    tick();
    tick();
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    grant("postrst_gnt", 0);
    tick();
    req_valid = '0;
    #1;
    chk("postrst_no_stale", 32'(rsp_valid), 0);
    tick();
    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
